// File: rtl/multiciclo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : multiciclo_ctrl
// Description : Multicycle RV32I control FSM with memory handshake, memory
//               timeout trap and retired-instruction counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiciclo_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       opcode_i,
  input  logic             brflag_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             reg_we_o,
  output logic             memtoreg_o,
  output logic [1:0]       alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [1:0]       aluop_o,
  output logic             halt_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_WB_MEM   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_WB_ALU   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [3:0]        r_state;
  logic [3:0]        w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;
  logic              w_mem_wait;
  logic              w_wait_last;
  logic              w_timeout;
  logic              w_retire;

  // A memory wait is any request cycle without ready.
  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR)) && !mem_ready_i;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
      assign w_wait_last = (r_wait == WAIT_LAST);
    end else begin : g_no_timeout
      assign w_wait_last = 1'b0;
    end
  endgenerate

  assign w_timeout = w_mem_wait && w_wait_last;

  assign w_retire = (r_state == S_WB_ALU) || (r_state == S_WB_MEM) ||
                    (r_state == S_BRANCH) ||
                    ((r_state == S_MEM_WR) && mem_ready_i);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:  w_state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i)    w_state_next = S_DECODE;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_R:                w_state_next = S_EXEC_R;
          OP_I:                w_state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:   w_state_next = S_MEM_ADDR;
          OP_BRANCH:           w_state_next = S_BRANCH;
          default:             w_state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_state_next = opcode_i[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready_i)    w_state_next = S_WB_MEM;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_WB_MEM: w_state_next = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready_i)    w_state_next = S_FETCH;
        else if (w_timeout) w_state_next = S_TRAP;
      end
      S_EXEC_R: w_state_next = S_WB_ALU;
      S_EXEC_I: w_state_next = S_WB_ALU;
      S_WB_ALU: w_state_next = S_FETCH;
      S_BRANCH: w_state_next = S_FETCH;
      S_TRAP:   w_state_next = S_TRAP;
      // Unused encodings fall back to a clean restart.
      default:  w_state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_RESET;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_wait <= '0;
      end else if (w_mem_wait) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    iord_o     = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_src_o   = 1'b0;
    reg_we_o   = 1'b0;
    memtoreg_o = 1'b0;
    alusrca_o  = 2'b00;
    alusrcb_o  = 2'b00;
    aluop_o    = 2'b00;
    halt_o     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req_o = 1'b1;
        alusrcb_o = 2'b01;
        ir_we_o   = mem_ready_i;
        pc_we_o   = mem_ready_i;
      end
      // ALUOut captures OldPC + (imm<<1) as the branch target.
      S_DECODE: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b11;
      end
      S_MEM_ADDR: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_WB_MEM: begin
        reg_we_o   = 1'b1;
        memtoreg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
      end
      S_EXEC_R: begin
        alusrca_o = 2'b01;
        aluop_o   = 2'b10;
      end
      S_EXEC_I: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        aluop_o   = 2'b11;
      end
      S_WB_ALU: reg_we_o = 1'b1;
      S_BRANCH: begin
        alusrca_o = 2'b01;
        aluop_o   = 2'b01;
        pc_src_o  = 1'b1;
        pc_we_o   = brflag_i;
      end
      S_TRAP:  halt_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o   = r_state;
  assign instret_o = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multiciclo_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_multiciclo_ctrl
// Description : Directed scoreboard bench for multiciclo_ctrl (MEM_TIMEOUT=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiciclo_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [6:0]       opcode_i;
  logic             brflag_i;
  logic             mem_ready_i;
  logic             mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o;
  logic             reg_we_o, memtoreg_o, halt_o;
  logic [1:0]       alusrca_o, alusrcb_o, aluop_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instret_o;

  multiciclo_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .brflag_i(brflag_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .iord_o(iord_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .reg_we_o(reg_we_o), .memtoreg_o(memtoreg_o), .alusrca_o(alusrca_o),
    .alusrcb_o(alusrcb_o), .aluop_o(aluop_o), .halt_o(halt_o),
    .state_o(state_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Packed as {req,we,iord,ir_we,pc_we,pc_src,reg_we,m2r,A,B,aluop,halt}.
  function automatic logic [14:0] ctrl_model(input logic [3:0] st, input logic rdy,
                                             input logic br);
    logic req, we, iord, irwe, pcwe, pcsrc, rwe, m2r, halt;
    logic [1:0] a, b, op;
    {req, we, iord, irwe, pcwe, pcsrc, rwe, m2r, halt} = '0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (st)
      4'd1:  begin req = 1; b = 2'b01; irwe = rdy; pcwe = rdy; end
      4'd2:  begin a = 2'b10; b = 2'b11; end
      4'd3:  begin a = 2'b01; b = 2'b10; end
      4'd4:  begin req = 1; iord = 1; end
      4'd5:  begin rwe = 1; m2r = 1; end
      4'd6:  begin req = 1; we = 1; iord = 1; end
      4'd7:  begin a = 2'b01; op = 2'b10; end
      4'd8:  begin a = 2'b01; b = 2'b10; op = 2'b11; end
      4'd9:  rwe = 1;
      4'd10: begin a = 2'b01; op = 2'b01; pcsrc = 1; pcwe = br; end
      4'd11: halt = 1;
      default: ;
    endcase
    return {req, we, iord, irwe, pcwe, pcsrc, rwe, m2r, a, b, op, halt};
  endfunction

  // One clock cycle: drive inputs, push the expectation, compare at negedge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic rdy,
                     input logic br, input logic [6:0] op);
    exp_t e, g;
    logic [14:0] obs;
    mem_ready_i = rdy;
    brflag_i    = br;
    opcode_i    = op;
    e.tag = tag; e.st = st; e.ctrl = ctrl_model(st, rdy, br); e.cnt = exp_instret;
    sb.push_back(e);
    @(negedge clk_i);
    g   = sb.pop_front();
    obs = {mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o,
           memtoreg_o, alusrca_o, alusrcb_o, aluop_o, halt_o};
    n_tests++;
    assert (state_o === g.st) else begin
      n_fail++;
      $error("FAIL %s.state observed=%0d expected=%0d", g.tag, state_o, g.st);
    end
    n_tests++;
    assert (obs === g.ctrl) else begin
      n_fail++;
      $error("FAIL %s.ctrl observed=%b expected=%b", g.tag, obs, g.ctrl);
    end
    n_tests++;
    assert (instret_o === g.cnt) else begin
      n_fail++;
      $error("FAIL %s.instret observed=%0d expected=%0d", g.tag, instret_o, g.cnt);
    end
    if (st == 4'd5 || st == 4'd9 || st == 4'd10 || (st == 4'd6 && rdy))
      exp_instret = exp_instret + 32'd1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; opcode_i = '0; brflag_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cyc("rst_hold", 4'd0, 1'b1, 1'b1, OP_R);
    rst_ni = 1'b1;
    cyc("rst_rel", 4'd0, 1'b1, 1'b0, OP_R);

    // R-type, zero wait
    cyc("r_fetch", 4'd1, 1'b1, 1'b0, OP_R);
    cyc("r_dec",   4'd2, 1'b1, 1'b0, OP_R);
    cyc("r_exec",  4'd7, 1'b1, 1'b0, OP_R);
    cyc("r_wb",    4'd9, 1'b1, 1'b0, OP_R);

    // Load with three wait cycles; ready lands on the last allowed cycle
    cyc("ld_fetch", 4'd1, 1'b1, 1'b0, OP_LD);
    cyc("ld_dec",   4'd2, 1'b1, 1'b0, OP_LD);
    cyc("ld_addr",  4'd3, 1'b1, 1'b0, OP_LD);
    for (int i = 0; i < 3; i++) cyc("ld_wait", 4'd4, 1'b0, 1'b0, OP_LD);
    cyc("ld_rdy",   4'd4, 1'b1, 1'b0, OP_LD);
    cyc("ld_wb",    4'd5, 1'b1, 1'b0, OP_LD);

    // Store with one wait cycle
    cyc("st_fetch", 4'd1, 1'b1, 1'b0, OP_ST);
    cyc("st_dec",   4'd2, 1'b1, 1'b0, OP_ST);
    cyc("st_addr",  4'd3, 1'b1, 1'b0, OP_ST);
    cyc("st_wait",  4'd6, 1'b0, 1'b0, OP_ST);
    cyc("st_rdy",   4'd6, 1'b1, 1'b0, OP_ST);

    // Branch taken, then not taken
    cyc("bt_fetch", 4'd1,  1'b1, 1'b1, OP_BR);
    cyc("bt_dec",   4'd2,  1'b1, 1'b1, OP_BR);
    cyc("bt_br",    4'd10, 1'b1, 1'b1, OP_BR);
    cyc("bn_fetch", 4'd1,  1'b1, 1'b0, OP_BR);
    cyc("bn_dec",   4'd2,  1'b1, 1'b0, OP_BR);
    cyc("bn_br",    4'd10, 1'b1, 1'b0, OP_BR);

    // I-type
    cyc("i_fetch", 4'd1, 1'b1, 1'b0, OP_I);
    cyc("i_dec",   4'd2, 1'b1, 1'b0, OP_I);
    cyc("i_exec",  4'd8, 1'b1, 1'b0, OP_I);
    cyc("i_wb",    4'd9, 1'b1, 1'b0, OP_I);

    // Fetch timeout: four request cycles without ready
    for (int i = 0; i < 4; i++) cyc("to_fetch", 4'd1, 1'b0, 1'b0, OP_R);
    for (int i = 0; i < 20; i++)
      cyc("to_trap", 4'd11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), OP_R);

    // Asynchronous reset out of TRAP
    rst_ni = 1'b0;
    #1;
    n_tests++;
    assert (state_o === 4'd0 && halt_o === 1'b0 && instret_o === '0) else begin
      n_fail++;
      $error("FAIL async_rst observed=state%0d/halt%b/cnt%0d expected=state0/halt0/cnt0",
             state_o, halt_o, instret_o);
    end
    exp_instret = 0;
    cyc("rst2_hold", 4'd0, 1'b0, 1'b0, OP_R);
    rst_ni = 1'b1;
    cyc("rst2_rel",  4'd0, 1'b0, 1'b0, OP_R);

    // Ready on the fourth request cycle wins over the timeout
    for (int i = 0; i < 3; i++) cyc("nt_wait", 4'd1, 1'b0, 1'b0, OP_R);
    cyc("nt_rdy",  4'd1, 1'b1, 1'b0, OP_R);
    cyc("nt_dec",  4'd2, 1'b1, 1'b0, OP_R);
    cyc("nt_exec", 4'd7, 1'b1, 1'b0, OP_R);
    cyc("nt_wb",   4'd9, 1'b1, 1'b0, OP_R);

    // Illegal opcode traps from DECODE; instret frozen
    cyc("ill_fetch", 4'd1, 1'b1, 1'b0, OP_BAD);
    cyc("ill_dec",   4'd2, 1'b1, 1'b0, OP_BAD);
    for (int i = 0; i < 22; i++) cyc("ill_trap", 4'd11, 1'b1, 1'b1, OP_BAD);

    rst_ni = 1'b0;
    exp_instret = 0;
    cyc("rst3_hold", 4'd0, 1'b1, 1'b0, OP_R);
    rst_ni = 1'b1;
    cyc("rst3_rel",  4'd0, 1'b1, 1'b0, OP_R);
    cyc("rst3_fetch", 4'd1, 1'b1, 1'b0, OP_R);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
